// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - EX branch outcome in, BTB update and IF redirect out
interface branch_resolve_unit_if #(parameter int CNT_WIDTH = 32);
  logic                 ex_isBranchInst_i;
  logic [31:0]          ex_branch_inst_pc_i;
  logic                 ex_actual_taken_i;
  logic [31:0]          ex_real_branch_target_i;
  logic                 idex_pre_taken_i;
  logic [31:0]          idex_predict_branch_target_i;
  logic [1:0]           idex_predict_counter_i;
  logic                 redirect_ack_i;
  logic                 upd_valid_o;
  logic [31:0]          upd_pc_o;
  logic [1:0]           upd_counter_o;
  logic [31:0]          upd_target_o;
  logic                 redirect_o;
  logic [31:0]          redirect_pc_o;
  logic                 flush_o;
  logic [CNT_WIDTH-1:0] branch_cnt_o;
  logic [CNT_WIDTH-1:0] mispredict_cnt_o;

  modport master (
    input  ex_isBranchInst_i, ex_branch_inst_pc_i, ex_actual_taken_i,
           ex_real_branch_target_i, idex_pre_taken_i,
           idex_predict_branch_target_i, idex_predict_counter_i, redirect_ack_i,
    output upd_valid_o, upd_pc_o, upd_counter_o, upd_target_o,
           redirect_o, redirect_pc_o, flush_o, branch_cnt_o, mispredict_cnt_o
  );

  modport slave (
    output ex_isBranchInst_i, ex_branch_inst_pc_i, ex_actual_taken_i,
           ex_real_branch_target_i, idex_pre_taken_i,
           idex_predict_branch_target_i, idex_predict_counter_i, redirect_ack_i,
    input  upd_valid_o, upd_pc_o, upd_counter_o, upd_target_o,
           redirect_o, redirect_pc_o, flush_o, branch_cnt_o, mispredict_cnt_o
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves EX branches, feeds the BTB and redirects IF on mispredict
module branch_resolve_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [5:0]            stall,
  branch_resolve_unit_if.master bus
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] REDIRECT = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]           state_q, state_d;
  logic                 upd_valid_q, upd_valid_d;
  logic [31:0]          upd_pc_q, upd_pc_d;
  logic [1:0]           upd_counter_q, upd_counter_d;
  logic [31:0]          upd_target_q, upd_target_d;
  logic [31:0]          redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic        resolve;
  logic        mispredict;
  logic [1:0]  new_counter;
  logic [31:0] correct_pc;
  logic        unused_stall;

  assign unused_stall = ^{stall[5:4], stall[2:0]};

  // Wrong-path instructions sit in EX while redirecting, so only IDLE may resolve
  assign resolve = bus.ex_isBranchInst_i && !stall[3] && (state_q == IDLE);

  assign mispredict = (bus.ex_actual_taken_i != bus.idex_pre_taken_i) ||
                      (bus.ex_actual_taken_i && bus.idex_pre_taken_i &&
                       (bus.ex_real_branch_target_i != bus.idex_predict_branch_target_i));

  always_comb begin
    new_counter = bus.idex_predict_counter_i;
    if (bus.ex_actual_taken_i) begin
      if (bus.idex_predict_counter_i != 2'd3) new_counter = bus.idex_predict_counter_i + 2'd1;
    end else begin
      if (bus.idex_predict_counter_i != 2'd0) new_counter = bus.idex_predict_counter_i - 2'd1;
    end
  end

  // Not-taken fall-through skips the delay slot
  assign correct_pc = bus.ex_actual_taken_i ? bus.ex_real_branch_target_i
                                            : bus.ex_branch_inst_pc_i + 32'd8;

  always_comb begin
    state_d          = state_q;
    redirect_pc_d    = redirect_pc_q;
    upd_valid_d      = resolve;
    upd_pc_d         = 32'd0;
    upd_counter_d    = 2'd0;
    upd_target_d     = 32'd0;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;

    if (resolve) begin
      upd_pc_d      = bus.ex_branch_inst_pc_i;
      upd_counter_d = new_counter;
      upd_target_d  = bus.ex_actual_taken_i ? bus.ex_real_branch_target_i
                                            : bus.idex_predict_branch_target_i;
      if (branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + CNT_ONE;
      if (mispredict && (mispredict_cnt_q != CNT_MAX)) mispredict_cnt_d = mispredict_cnt_q + CNT_ONE;
    end

    case (state_q)
      IDLE: begin
        if (resolve && mispredict) begin
          state_d       = REDIRECT;
          redirect_pc_d = correct_pc;
        end
      end
      default: begin
        if (bus.redirect_ack_i) begin
          state_d       = IDLE;
          redirect_pc_d = 32'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= IDLE;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= 32'd0;
      upd_counter_q    <= 2'd0;
      upd_target_q     <= 32'd0;
      redirect_pc_q    <= 32'd0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      upd_valid_q      <= upd_valid_d;
      upd_pc_q         <= upd_pc_d;
      upd_counter_q    <= upd_counter_d;
      upd_target_q     <= upd_target_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bus.upd_valid_o      = upd_valid_q;
  assign bus.upd_pc_o         = upd_pc_q;
  assign bus.upd_counter_o    = upd_counter_q;
  assign bus.upd_target_o     = upd_target_q;
  assign bus.redirect_o       = (state_q == REDIRECT);
  assign bus.flush_o          = (state_q == REDIRECT);
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign bus.branch_cnt_o     = branch_cnt_q;
  assign bus.mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic        clk;
  logic        rstn;
  logic [5:0]  stall;
  logic        ex_br;
  logic [31:0] pc;
  logic        act;
  logic [31:0] real_tgt;
  logic        pre;
  logic [31:0] ptgt;
  logic [1:0]  ctr;
  logic        ack;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_redir;
  logic [31:0] m_rpc;
  bit          m_uv;
  logic [31:0] m_upc;
  int          m_uctr;
  logic [31:0] m_utgt;
  longint      m_bc;
  longint      m_mc;

  branch_resolve_unit_if #(.CNT_WIDTH(32)) b32 ();
  branch_resolve_unit_if #(.CNT_WIDTH(4))  b4 ();

  assign b32.ex_isBranchInst_i            = ex_br;
  assign b32.ex_branch_inst_pc_i          = pc;
  assign b32.ex_actual_taken_i            = act;
  assign b32.ex_real_branch_target_i      = real_tgt;
  assign b32.idex_pre_taken_i             = pre;
  assign b32.idex_predict_branch_target_i = ptgt;
  assign b32.idex_predict_counter_i       = ctr;
  assign b32.redirect_ack_i               = ack;
  assign b4.ex_isBranchInst_i             = ex_br;
  assign b4.ex_branch_inst_pc_i           = pc;
  assign b4.ex_actual_taken_i             = act;
  assign b4.ex_real_branch_target_i       = real_tgt;
  assign b4.idex_pre_taken_i              = pre;
  assign b4.idex_predict_branch_target_i  = ptgt;
  assign b4.idex_predict_counter_i        = ctr;
  assign b4.redirect_ack_i                = ack;

  branch_resolve_unit #(.CNT_WIDTH(32)) dut (.clk(clk), .rstn(rstn), .stall(stall), .bus(b32));
  branch_resolve_unit #(.CNT_WIDTH(4))  dut4 (.clk(clk), .rstn(rstn), .stall(stall), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_redir = 0; m_rpc = 0; m_uv = 0; m_upc = 0; m_uctr = 0; m_utgt = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic check_all();
    longint sat4_b, sat4_m;
    sat4_b = (m_bc > 15) ? 15 : m_bc;
    sat4_m = (m_mc > 15) ? 15 : m_mc;
    chk("upd_valid", b32.upd_valid_o, m_uv);
    chk("upd_pc", b32.upd_pc_o, m_upc);
    chk("upd_counter", b32.upd_counter_o, m_uctr);
    chk("upd_target", b32.upd_target_o, m_utgt);
    chk("redirect", b32.redirect_o, m_redir);
    chk("flush", b32.flush_o, m_redir);
    chk("redirect_pc", b32.redirect_pc_o, m_rpc);
    chk("branch_cnt", b32.branch_cnt_o, m_bc);
    chk("mispredict_cnt", b32.mispredict_cnt_o, m_mc);
    chk("branch_cnt4", b4.branch_cnt_o, sat4_b);
    chk("mispredict_cnt4", b4.mispredict_cnt_o, sat4_m);
    chk("redirect4", b4.redirect_o, m_redir);
  endtask

  // Predict the effect of the current inputs, clock once, then compare.
  task automatic tick();
    bit res, mis;
    int c;
    res = ex_br && !stall[3] && !m_redir;
    mis = (act != pre) || (act && pre && (real_tgt != ptgt));
    c = int'(ctr);
    m_uv   = res;
    m_upc  = res ? pc : 32'd0;
    m_uctr = !res ? 0 : (act ? ((c + 1 > 3) ? 3 : c + 1) : ((c - 1 < 0) ? 0 : c - 1));
    m_utgt = !res ? 32'd0 : (act ? real_tgt : ptgt);
    if (m_redir) begin
      if (ack) begin m_redir = 0; m_rpc = 0; end
    end else if (res && mis) begin
      m_redir = 1;
      m_rpc = act ? real_tgt : pc + 32'd8;
    end
    if (res) m_bc++;
    if (res && mis) m_mc++;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_br(input logic [31:0] p, input logic pr, input logic [1:0] c,
                        input logic a, input logic [31:0] pt, input logic [31:0] rt);
    ex_br = 1; pc = p; pre = pr; ctr = c; act = a; ptgt = pt; real_tgt = rt;
  endtask

  initial begin
    rstn = 0; stall = 0; ex_br = 0; pc = 0; act = 0; real_tgt = 0; pre = 0; ptgt = 0; ctr = 0; ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rstn = 1;

    // correct not-taken
    set_br(32'h100, 0, 2'd1, 0, 32'h1234, 32'h0);
    tick();
    chk("tp1_counter", b32.upd_counter_o, 0);
    chk("tp1_target", b32.upd_target_o, 32'h1234);
    chk("tp1_redirect", b32.redirect_o, 0);
    ex_br = 0;
    tick();
    chk("tp1_pulse_end", b32.upd_valid_o, 0);

    // direction mispredict, ack on the 4th redirect cycle; wrong-path branch ignored
    set_br(32'h200, 0, 2'd1, 1, 32'h0, 32'h400);
    tick();
    chk("tp2_counter", b32.upd_counter_o, 2);
    chk("tp2_rpc", b32.redirect_pc_o, 32'h400);
    set_br(32'h300, 1, 2'd2, 0, 32'h10, 32'h20);
    tick();
    chk("ignore_upd", b32.upd_valid_o, 0);
    ex_br = 0;
    tick();
    tick();
    chk("tp2_hold", b32.flush_o, 1);
    ack = 1;
    tick();
    chk("tp2_idle", b32.redirect_o, 0);
    chk("tp2_mcnt", b32.mispredict_cnt_o, 1);
    ack = 0;

    // target mispredict, 1-cycle redirect
    set_br(32'h480, 1, 2'd3, 1, 32'h500, 32'h540);
    tick();
    chk("tp3_counter", b32.upd_counter_o, 3);
    chk("tp3_rpc", b32.redirect_pc_o, 32'h540);
    ex_br = 0; ack = 1;
    tick();
    ack = 0;

    // not-taken mispredict with PC wrap
    set_br(32'hFFFF_FFFC, 1, 2'd0, 0, 32'h800, 32'h900);
    tick();
    chk("wrap_rpc", b32.redirect_pc_o, 32'h4);
    chk("wrap_counter", b32.upd_counter_o, 0);
    ex_br = 0; ack = 1;
    tick();
    ack = 0;

    // stalled branch resolves once, followed by a back-to-back resolution
    set_br(32'h600, 0, 2'd2, 0, 32'h700, 32'h0);
    stall = 6'h08;
    repeat (3) tick();
    stall = 6'h37;
    tick();
    chk("stall_once", b32.upd_pc_o, 32'h600);
    set_br(32'h608, 1, 2'd2, 1, 32'h900, 32'h900);
    tick();
    ex_br = 0; stall = 0;
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ex_br = ($urandom_range(0, 3) != 0);
      stall = 6'($urandom);
      stall[3] = ($urandom_range(0, 3) == 0);
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 1) * 4) : $urandom;
      act = 1'($urandom);
      pre = 1'($urandom);
      ptgt = $urandom;
      real_tgt = ($urandom_range(0, 1) == 1) ? ptgt : $urandom;
      ctr = 2'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      tick();
    end
    chk("sat4_branch_cnt", b4.branch_cnt_o, 4'hF);

    // reset in the middle of a redirect
    ack = 0;
    set_br(32'h1000, 0, 2'd1, 1, 32'h0, 32'h2000);
    tick();
    ex_br = 0;
    chk("pre_reset_redirect", b32.redirect_o, 1);
    #2;
    rstn = 0;
    #1;
    model_reset();
    chk("async_redirect", b32.redirect_o, 0);
    chk("async_flush", b32.flush_o, 0);
    check_all();
    @(posedge clk);
    #1;
    rstn = 1;
    set_br(32'h3000, 1, 2'd1, 1, 32'h3100, 32'h3100);
    tick();
    chk("post_reset_upd", b32.upd_valid_o, 1);
    chk("post_reset_cnt", b32.branch_cnt_o, 1);
    ex_br = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
